// File: rtl/tfm_sched_if.sv
// Handshake and control bundle between the stage sequencer, the upstream sample source,
// the twiddle ROM / multiplier pair and the tfm_sched scheduler.
interface tfm_sched_if #(
    parameter int unsigned LOG2N = 6,
    parameter int unsigned STG_W = 3
);
    logic             start;
    logic [STG_W-1:0] stage;
    logic             in_valid;
    logic             in_ready;
    logic [LOG2N-2:0] rom_addr;
    logic             tfm_en;
    logic             tfm_out_val;
    logic             busy;
    logic             done;
    logic             err;

    modport master (
        output start, stage, in_valid, tfm_out_val,
        input  in_ready, rom_addr, tfm_en, busy, done, err
    );

    modport slave (
        input  start, stage, in_valid, tfm_out_val,
        output in_ready, rom_addr, tfm_en, busy, done, err
    );
endinterface

// File: rtl/tfm_sched.sv
// Per-stage twiddle scheduler for a radix-2 FFT: issues N/2 ROM addresses, enables the
// multiplier one cycle later, checks its fixed latency and counts returned results.
module tfm_sched #(
    parameter int unsigned LOG2N   = 6,
    parameter int unsigned STG_W   = 3,
    parameter int unsigned TFM_LAT = 2
) (
    input logic      clk,
    input logic      rst,
    tfm_sched_if.slave bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [LOG2N-1:0] HALF = {1'b1, {(LOG2N-1){1'b0}}};

    logic [1:0]         r_state;
    logic [STG_W-1:0]   r_stage;
    logic [LOG2N-1:0]   r_k;
    logic [LOG2N-1:0]   r_r;
    logic [LOG2N-2:0]   r_rom_addr;
    logic               r_tfm_en;
    logic               r_err;
    logic [TFM_LAT-1:0] r_lat_sr;

    logic               w_in_ready;
    logic               w_accept;
    logic               w_active;
    logic               w_ret;
    logic               w_lat_err;
    logic               w_stray;
    logic               w_start_ok;
    logic               w_start_bad;
    logic [LOG2N-1:0]   w_k_next;
    logic [LOG2N-1:0]   w_r_next;
    logic [LOG2N-1:0]   w_kmask;
    logic [STG_W-1:0]   w_shamt;
    logic [LOG2N-2:0]   w_addr;

    always_comb begin
        w_active    = (r_state == S_RUN) || (r_state == S_DRAIN);
        w_in_ready  = (r_state == S_RUN) && (r_k < HALF);
        w_accept    = bus.in_valid && w_in_ready;
        w_ret       = bus.tfm_out_val && w_active;
        w_k_next    = r_k + LOG2N'(w_accept);
        w_r_next    = r_r + LOG2N'(w_ret);
        w_lat_err   = w_active && (r_lat_sr[TFM_LAT-1] != bus.tfm_out_val);
        w_stray     = bus.tfm_out_val && !w_active;
        w_start_ok  = (r_state == S_IDLE) && bus.start && (32'(bus.stage) < LOG2N);
        w_start_bad = (r_state == S_IDLE) && bus.start && (32'(bus.stage) >= LOG2N);
        // Address = (k mod 2^s) << (LOG2N-1-s), formed at full k width then truncated.
        w_kmask     = r_k & ((LOG2N'(1) << r_stage) - LOG2N'(1));
        w_shamt     = STG_W'(LOG2N - 1) - r_stage;
        w_addr      = (LOG2N-1)'(w_kmask << w_shamt);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_stage    <= '0;
            r_k        <= '0;
            r_r        <= '0;
            r_rom_addr <= '0;
            r_tfm_en   <= 1'b0;
            r_err      <= 1'b0;
            r_lat_sr   <= '0;
        end else begin
            r_tfm_en    <= w_accept;
            r_lat_sr[0] <= r_tfm_en;
            for (int unsigned i = 1; i < TFM_LAT; i++) begin
                r_lat_sr[i] <= r_lat_sr[i-1];
            end

            if (w_accept) begin
                r_rom_addr <= w_addr;
                r_k        <= w_k_next;
            end
            if (w_ret) begin
                r_r <= w_r_next;
            end

            if (w_start_bad || w_lat_err || w_stray) begin
                r_err <= 1'b1;
            end else if (w_start_ok) begin
                r_err <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_start_ok) begin
                        r_stage <= bus.stage;
                        r_k     <= '0;
                        r_r     <= '0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_k_next == HALF) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (w_r_next == HALF) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready = w_in_ready;
    assign bus.rom_addr = r_rom_addr;
    assign bus.tfm_en   = r_tfm_en;
    assign bus.busy     = (r_state != S_IDLE);
    assign bus.done     = (r_state == S_DONE);
    assign bus.err      = r_err;
endmodule

// File: doc/tfm_sched.md
Name: tfm_sched

Overview:
- Per-stage scheduler for the radix-2 FFT twiddle factor multiplier.
- On start, it accepts N/2 butterfly samples from upstream via a valid/ready handshake and issues one synchronous twiddle-ROM address per accepted sample. It drives the multiplier enable one cycle later, aligned with ROM data.
- It tracks the multiplier's fixed 2-cycle latency, counts returned results, flags any latency mismatch, and pulses done when the stage is complete.
- It sits between the stage sequencer (start/stage) and the twiddle ROM / multiplier pair.

Parameters:
- LOG2N, 6, log2 of FFT size N; one stage performs N/2 twiddle multiplications.
- STG_W, 3, width of the stage index; must satisfy 2^STG_W >= LOG2N.
- TFM_LAT, 2, multiplier latency: cycles from en sampled high to out_val high.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous active-low reset.
- start  input  1  single-cycle request to run one stage; honoured only in IDLE.
- stage  input  STG_W  stage index s, sampled when start is accepted; legal range 0..LOG2N-1.
- in_valid  input  1  upstream sample available.
- in_ready  output  1  scheduler accepts a sample this cycle.
- rom_addr  output  LOG2N-1  twiddle ROM address (ROM read latency is 1 cycle).
- tfm_en  output  1  multiplier enable; upstream data is delayed one register to align with it.
- tfm_out_val  input  1  result-valid pulse from the multiplier.
- busy  output  1  stage in progress.
- done  output  1  one-cycle pulse: all N/2 results returned.
- err  output  1  sticky error flag; cleared on the next accepted start.

Behaviour:
- Reset (rst=0 at a clock edge):
  - State goes to IDLE; all counters and the latency shift register clear.
  - in_ready, tfm_en, busy, done and err are all 0; rom_addr is 0.
  - Reset mid-stage abandons the stage; no done is produced.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start=1 with stage < LOG2N: latch s, clear issue count k and return count r, clear err, go to RUN.
  - start=1 with stage >= LOG2N: set err and stay in IDLE.
- RUN:
  - in_ready = (k < N/2).
  - On accept (in_valid & in_ready): rom_addr <= (k mod 2^s) << (LOG2N-1-s), truncated to LOG2N-1 bits, then k <= k+1.
  - tfm_en is the accept strobe registered once, so it is high in the cycle after the accept.
  - When k reaches N/2, go to DRAIN; in_ready is 0 from that cycle on.
  - in_valid low stalls issue; there is no timeout.
- DRAIN: wait until r = N/2, then go to DONE.
- DONE: done=1 for exactly one cycle, then return to IDLE.
- busy = 1 in RUN, DRAIN and DONE.
- rom_addr holds its last value when there is no accept.
- start outside IDLE is ignored; it is neither queued nor flagged.
- Return counting:
  - r increments on each tfm_out_val=1 while in RUN or DRAIN.
  - tfm_out_val outside RUN/DRAIN sets err and is not counted.
- Latency check:
  - A TFM_LAT-deep shift register is fed by tfm_en.
  - Its tail must equal tfm_out_val every cycle in RUN/DRAIN; any mismatch sets err.
  - The stage still completes on r = N/2, so a missing pulse hangs the scheduler in DRAIN until reset.
- Simultaneous events:
  - An accept and a tfm_out_val in the same cycle both count.
  - The final tfm_out_val moves DRAIN to DONE on the next edge, so done is asserted 1 cycle after the last out_val.
- Widths:
  - k and r are LOG2N bits wide (they must reach N/2).
  - The address shift is computed at LOG2N bits, then truncated.

Test Plan:
- LOG2N=6, stage=2, in_valid held high, start pulsed at cycle 0:
  - Accepts occur in cycles 1..32.
  - rom_addr sequence is 0,8,16,24 repeating 8 times.
  - tfm_en is high in cycles 2..33.
  - With a model multiplier, tfm_out_val is high in cycles 4..35 and done pulses at cycle 36.
  - err stays 0 and busy stays high in cycles 1..36.
- stage=0: all 32 addresses are 0. stage=5: addresses are 0..31 in order. Both runs end with done and err=0.
- in_valid toggling 1,0,1,0: in_ready stays high while k < 32, tfm_en follows each accept by 1 cycle, and the total is 32 accepts with done and no extra accepts.
- Error injection:
  - Model multiplier drops 1 out_val: err=1 at the expected cycle and the FSM stays in DRAIN.
  - An extra out_val while IDLE: err=1.
  - A new valid start clears err.
- start with stage=6: stays IDLE, busy=0, err=1. start pulsed during RUN: ignored, and the sequence and count are unchanged.
- rst=0 at cycle 10 of a stage (k=9): next cycle is IDLE with all outputs 0. A fresh start then completes all 32 with correct addresses.
